bp_resolve_history_unit: RTL and testbench
==========================================

Name: bp_resolve_history_unit

Overview:
- Resolution and learning end of the perceptron B-branch predictor.
- Holds the in-flight queue of predicted B branches, the committed global history register (GHR) and the 228-entry perceptron weight table, and drives all of them to the predictor.
- Accepts resolved outcomes from execute in program order and redirects fetch on a mispredict. On a direction mispredict it also trains the weights.

Parameters:
- DEPTH, 8: pending-branch queue entries (power of 2).
- HIST, 20: committed GHR entries.
- TABLE, 228: weight-table rows.
- TRAINW, 8: history bits used for training; row = TRAINW+1 signed 8-bit weights.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_pushValid  in  1  predictor offers new predicted B branches
- i_pushNum_3  in  3  number of valid slots, 0..4
- i_pushEntries_260  in  4*65  slot k = bits k*65+:65; {target32, pc32, predTaken1}, taken at bit 0; slot 0 oldest
- o_pushReady  out  1  free slots >= 4 and FSM IDLE
- i_resolveValid  in  1  execute resolves the oldest pending B
- i_resolveTaken  in  1  actual direction
- i_resolveTarget_32  in  32  actual taken target
- o_resolveReady  out  1  FSM IDLE
- o_redirect  out  1  one-cycle mispredict pulse
- o_correctPC_32  out  32  fetch target while o_redirect=1, else 0
- o_pendingB_8  out  8  pending entry count
- o_globalHistoryRegister_660  out  HIST*33  entry i = bits i*33+:33; bit 0 taken, bits 1+:32 pc; entry 0 newest
- o_weightTable_16416  out  TABLE*72  row r = bits r*72+:72; weight j = r*72+j*8+:8; j=8 is bias
- o_protoErr  out  1  one-cycle pulse on resolve with empty queue

Behaviour:
- Reset, synchronous:
  - queue empty, count 0.
  - GHR all 0; all weights 0; FSM IDLE.
  - o_redirect=0, o_correctPC_32=0, o_protoErr=0.
- Push: accepted when i_pushValid & o_pushReady.
  - Slots 0..i_pushNum_3-1 are appended in slot order.
  - i_pushNum_3 > 4 is clamped to 4.
  - Push with o_pushReady=0 is dropped silently.
- Resolve: accepted when i_resolveValid & o_resolveReady. It compares against the head entry.
  - dirErr = resolveTaken != predTaken.
  - tgtErr = resolveTaken & predTaken & (resolveTarget != target).
  - Neither error: pop the head. Shift {pc, resolveTaken} into GHR entry 0; entries move up one; entry HIST-1 is discarded.
- Mispredict (dirErr | tgtErr), registered, effects visible at t+1:
  - o_redirect=1 for exactly one cycle.
  - o_correctPC_32 = resolveTarget if taken, else pc+4 (mod 2^32).
  - Entire queue flushed, count 0.
  - GHR shift with the actual outcome, as on a correct resolve.
  - A push in the same cycle is discarded.
- Simultaneous push + correct resolve: pop and append in the same cycle; count = count - 1 + n.
- Resolve on empty queue: ignored, with o_protoErr pulse at t+1.
- Training FSM:
  - IDLE→TRAIN only on dirErr. TRAIN lasts one cycle, then IDLE. tgtErr alone does not train.
  - In TRAIN, the row latched at t is updated: row = pc mod TABLE, outcome o = resolveTaken, h_j = GHR entry j taken bit before the t shift.
  - w_j += (h_j == o) ? +1 : -1 for j < TRAINW; bias += o ? +1 : -1.
  - Signed saturation at [-128, 127].
  - New weights visible on o_weightTable at t+2.
  - o_pushReady = o_resolveReady = 0 during TRAIN.
- Reset asserted during TRAIN: returns to IDLE, weights 0, no partial write.
- o_pendingB_8 and both ready signals are registered-state derived, with no combinational path from inputs.

Test Plan:
- Reset, then push 3 entries (pc 0x100/0x200/0x300, predTaken 0, target 0) → o_pendingB_8=3, GHR all 0, o_pushReady=1.
- Resolve not-taken ×3 on those entries → count 0, GHR[0]={0x300,0}, GHR[2]={0x100,0}, o_redirect never asserts.
- Entry pc=0x1C8 predTaken=0, resolve taken target 0x400, GHR taken bits 0..7 = 1 → o_redirect=1, o_correctPC=0x400 at t+1. At t+2, row 0x1C8 mod 228=0 has w0..7=+1, bias=+1. Readies low for 1 cycle; queue empty.
- Row 0 with all weights at 127: 3 directed matching direction-mispredicts → weights stay 127. Mismatch case → weights decrement to 126.
- Taken/taken with target mismatch 0x500 vs predicted 0x600 → redirect to 0x500, no weight change, readies stay high.
- Resolve with empty queue → o_protoErr pulse, state unchanged. Push 4 with 5 pending (DEPTH=8) → o_pushReady=0, push dropped, count stays 5.

Source files
------------

// File: rtl/bp_resolve_history_unit_if.sv
// rtl/bp_resolve_history_unit_if.sv - push/resolve/redirect bus of the predictor resolve-and-learn unit
interface bp_resolve_history_unit_if #(
    parameter int HIST   = 20,
    parameter int TABLE  = 228,
    parameter int TRAINW = 8
);
    logic                           i_pushValid;
    logic [2:0]                     i_pushNum_3;
    logic [259:0]                   i_pushEntries_260;
    logic                           o_pushReady;
    logic                           i_resolveValid;
    logic                           i_resolveTaken;
    logic [31:0]                    i_resolveTarget_32;
    logic                           o_resolveReady;
    logic                           o_redirect;
    logic [31:0]                    o_correctPC_32;
    logic [7:0]                     o_pendingB_8;
    logic [HIST*33-1:0]             o_globalHistoryRegister_660;
    logic [TABLE*(TRAINW+1)*8-1:0]  o_weightTable_16416;
    logic                           o_protoErr;

    modport master (
        output i_pushValid, i_pushNum_3, i_pushEntries_260,
        output i_resolveValid, i_resolveTaken, i_resolveTarget_32,
        input  o_pushReady, o_resolveReady, o_redirect, o_correctPC_32,
        input  o_pendingB_8, o_globalHistoryRegister_660, o_weightTable_16416, o_protoErr
    );

    modport slave (
        input  i_pushValid, i_pushNum_3, i_pushEntries_260,
        input  i_resolveValid, i_resolveTaken, i_resolveTarget_32,
        output o_pushReady, o_resolveReady, o_redirect, o_correctPC_32,
        output o_pendingB_8, o_globalHistoryRegister_660, o_weightTable_16416, o_protoErr
    );
endinterface

// File: rtl/bp_resolve_history_unit.sv
// rtl/bp_resolve_history_unit.sv - pending-branch queue, committed GHR and perceptron weight training
module bp_resolve_history_unit #(
    parameter int DEPTH  = 8,
    parameter int HIST   = 20,
    parameter int TABLE  = 228,
    parameter int TRAINW = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    bp_resolve_history_unit_if.slave bus
);
    localparam int PTRW  = $clog2(DEPTH);
    localparam int CNTW  = PTRW + 1;
    localparam int ROWW  = (TRAINW + 1) * 8;
    localparam int ROWIW = $clog2(TABLE);

    typedef enum logic {S_IDLE, S_TRAIN} state_t;

    state_t              state_q, state_d;
    logic [31:0]         q_pc_q [DEPTH];
    logic [31:0]         q_pc_d [DEPTH];
    logic [31:0]         q_tgt_q [DEPTH];
    logic [31:0]         q_tgt_d [DEPTH];
    logic                q_pt_q [DEPTH];
    logic                q_pt_d [DEPTH];
    logic [PTRW-1:0]     head_q, head_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic                ghr_t_q [HIST];
    logic                ghr_t_d [HIST];
    logic [31:0]         ghr_pc_q [HIST];
    logic [31:0]         ghr_pc_d [HIST];
    logic signed [7:0]   w_q [TABLE][TRAINW+1];
    logic signed [7:0]   w_d [TABLE][TRAINW+1];
    logic [ROWIW-1:0]    trow_q, trow_d;
    logic                to_q, to_d;
    logic [TRAINW-1:0]   th_q, th_d;
    logic                redirect_q, redirect_d;
    logic [31:0]         cpc_q, cpc_d;
    logic                proto_q, proto_d;

    logic                push_ready, resolve_ready;
    logic                push_acc, res_acc, do_res, mis, dir_err, tgt_err, empty;
    logic [31:0]         head_pc, head_tgt;
    logic                head_pt;
    logic [2:0]          push_n;
    logic [PTRW-1:0]     idx;
    logic [HIST*33-1:0]  ghr_flat;
    logic [TABLE*ROWW-1:0] wt_flat;

    function automatic logic signed [7:0] sat_step(input logic signed [7:0] w, input logic up);
        if (up && w == 8'sh7F)
            return w;
        if (!up && w == 8'sh80)
            return w;
        return up ? w + 8'sd1 : w - 8'sd1;
    endfunction

    // FSM output process: both readies depend only on registered state.
    always_comb begin
        push_ready    = 1'b0;
        resolve_ready = 1'b0;
        if (state_q == S_IDLE) begin
            resolve_ready = 1'b1;
            push_ready    = (CNTW'(DEPTH) - count_q) >= CNTW'(4);
        end
    end

    assign empty    = (count_q == '0);
    assign head_pc  = q_pc_q[head_q];
    assign head_tgt = q_tgt_q[head_q];
    assign head_pt  = q_pt_q[head_q];
    assign res_acc  = bus.i_resolveValid & resolve_ready;
    assign push_acc = bus.i_pushValid & push_ready;
    assign do_res   = res_acc & ~empty;
    assign dir_err  = bus.i_resolveTaken != head_pt;
    assign tgt_err  = bus.i_resolveTaken & head_pt & (bus.i_resolveTarget_32 != head_tgt);
    assign mis      = do_res & (dir_err | tgt_err);
    assign push_n   = (bus.i_pushNum_3 > 3'd4) ? 3'd4 : bus.i_pushNum_3;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (do_res && dir_err) state_d = S_TRAIN;
            S_TRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        q_pc_d     = q_pc_q;
        q_tgt_d    = q_tgt_q;
        q_pt_d     = q_pt_q;
        head_d     = head_q;
        count_d    = count_q;
        ghr_t_d    = ghr_t_q;
        ghr_pc_d   = ghr_pc_q;
        trow_d     = trow_q;
        to_d       = to_q;
        th_d       = th_q;
        redirect_d = 1'b0;
        cpc_d      = 32'd0;
        proto_d    = res_acc & empty;
        idx        = '0;
        if (do_res) begin
            ghr_t_d[0]  = bus.i_resolveTaken;
            ghr_pc_d[0] = head_pc;
            for (int i = 1; i < HIST; i++) begin
                ghr_t_d[i]  = ghr_t_q[i-1];
                ghr_pc_d[i] = ghr_pc_q[i-1];
            end
            // Training context is captured from the history as it stood before this shift.
            trow_d = ROWIW'(head_pc % TABLE);
            to_d   = bus.i_resolveTaken;
            for (int j = 0; j < TRAINW; j++)
                th_d[j] = ghr_t_q[j];
            if (mis) begin
                redirect_d = 1'b1;
                cpc_d      = bus.i_resolveTaken ? bus.i_resolveTarget_32 : head_pc + 32'd4;
                count_d    = '0;
            end else begin
                head_d  = head_q + PTRW'(1);
                count_d = count_q - CNTW'(1);
            end
        end
        if (push_acc && !mis) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < push_n) begin
                    idx          = head_q + PTRW'(count_q) + PTRW'(k);
                    q_pt_d[idx]  = bus.i_pushEntries_260[k*65];
                    q_pc_d[idx]  = bus.i_pushEntries_260[k*65+1 +: 32];
                    q_tgt_d[idx] = bus.i_pushEntries_260[k*65+33 +: 32];
                end
            end
            count_d = count_d + CNTW'(push_n);
        end
    end

    always_comb begin
        w_d = w_q;
        if (state_q == S_TRAIN) begin
            for (int j = 0; j < TRAINW; j++)
                w_d[trow_q][j] = sat_step(w_q[trow_q][j], th_q[j] == to_q);
            w_d[trow_q][TRAINW] = sat_step(w_q[trow_q][TRAINW], to_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            count_q    <= '0;
            trow_q     <= '0;
            to_q       <= 1'b0;
            th_q       <= '0;
            redirect_q <= 1'b0;
            cpc_q      <= 32'd0;
            proto_q    <= 1'b0;
            for (int i = 0; i < HIST; i++) begin
                ghr_t_q[i]  <= 1'b0;
                ghr_pc_q[i] <= 32'd0;
            end
            for (int r = 0; r < TABLE; r++)
                for (int j = 0; j <= TRAINW; j++)
                    w_q[r][j] <= 8'sd0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            count_q    <= count_d;
            trow_q     <= trow_d;
            to_q       <= to_d;
            th_q       <= th_d;
            redirect_q <= redirect_d;
            cpc_q      <= cpc_d;
            proto_q    <= proto_d;
            ghr_t_q    <= ghr_t_d;
            ghr_pc_q   <= ghr_pc_d;
            w_q        <= w_d;
        end
    end

    // Queue payload needs no reset: entries are only read while counted as pending.
    always_ff @(posedge i_clk) begin
        q_pc_q  <= q_pc_d;
        q_tgt_q <= q_tgt_d;
        q_pt_q  <= q_pt_d;
    end

    always_comb begin
        ghr_flat = '0;
        for (int i = 0; i < HIST; i++)
            ghr_flat[i*33 +: 33] = {ghr_pc_q[i], ghr_t_q[i]};
    end

    always_comb begin
        wt_flat = '0;
        for (int r = 0; r < TABLE; r++)
            for (int j = 0; j <= TRAINW; j++)
                wt_flat[r*ROWW + j*8 +: 8] = w_q[r][j];
    end

    assign bus.o_pushReady                 = push_ready;
    assign bus.o_resolveReady              = resolve_ready;
    assign bus.o_redirect                  = redirect_q;
    assign bus.o_correctPC_32              = cpc_q;
    assign bus.o_pendingB_8                = 8'(count_q);
    assign bus.o_protoErr                  = proto_q;
    assign bus.o_globalHistoryRegister_660 = ghr_flat;
    assign bus.o_weightTable_16416         = wt_flat;
endmodule

// File: tb/tb_bp_resolve_history_unit.sv
// tb/tb_bp_resolve_history_unit.sv - directed and random checks against a queue/array reference model
module tb_bp_resolve_history_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bp_resolve_history_unit_if bus ();

    bp_resolve_history_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pt;
    } ent_t;

    ent_t        mq[$];
    logic        mg_t [20];
    logic [31:0] mg_pc [20];
    int          mw [228][9];
    bit          m_train;
    int          m_row;
    bit          m_o;
    bit          m_h [8];
    logic        e_redirect;
    logic [31:0] e_cpc;
    logic        e_proto;

    function automatic int clamp(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 20; i++) begin
            mg_t[i]  = 1'b0;
            mg_pc[i] = 32'd0;
        end
        for (int r = 0; r < 228; r++)
            for (int j = 0; j < 9; j++)
                mw[r][j] = 0;
        m_train    = 0;
        e_redirect = 1'b0;
        e_cpc      = 32'd0;
        e_proto    = 1'b0;
    endtask

    task automatic model_step();
        bit   preadyv, rreadyv, mis, taken, dir, tge;
        bit   hsnap [8];
        ent_t h;
        int   n;
        logic [64:0] slot;
        if (rst) begin
            model_reset();
            return;
        end
        preadyv    = (8 - mq.size() >= 4) && !m_train;
        rreadyv    = !m_train;
        e_redirect = 1'b0;
        e_cpc      = 32'd0;
        e_proto    = 1'b0;
        mis        = 0;
        if (m_train) begin
            for (int j = 0; j < 8; j++)
                mw[m_row][j] = clamp(mw[m_row][j] + ((m_h[j] == m_o) ? 1 : -1));
            mw[m_row][8] = clamp(mw[m_row][8] + (m_o ? 1 : -1));
            m_train = 0;
        end
        if (bus.i_resolveValid && rreadyv) begin
            if (mq.size() == 0) begin
                e_proto = 1'b1;
            end else begin
                h     = mq[0];
                taken = bus.i_resolveTaken;
                dir   = taken != h.pt;
                tge   = taken && h.pt && (bus.i_resolveTarget_32 != h.tgt);
                for (int j = 0; j < 8; j++)
                    hsnap[j] = mg_t[j];
                for (int i = 19; i > 0; i--) begin
                    mg_t[i]  = mg_t[i-1];
                    mg_pc[i] = mg_pc[i-1];
                end
                mg_t[0]  = taken;
                mg_pc[0] = h.pc;
                if (dir || tge) begin
                    mis        = 1;
                    e_redirect = 1'b1;
                    e_cpc      = taken ? bus.i_resolveTarget_32 : h.pc + 32'd4;
                    mq.delete();
                    if (dir) begin
                        m_train = 1;
                        m_row   = int'(h.pc % 228);
                        m_o     = taken;
                        m_h     = hsnap;
                    end
                end else begin
                    void'(mq.pop_front());
                end
            end
        end
        if (bus.i_pushValid && preadyv && !mis) begin
            n = (bus.i_pushNum_3 > 4) ? 4 : int'(bus.i_pushNum_3);
            for (int k = 0; k < n; k++) begin
                slot = bus.i_pushEntries_260[k*65 +: 65];
                mq.push_back('{pc: slot[32:1], tgt: slot[64:33], pt: slot[0]});
            end
        end
    endtask

    function automatic logic [659:0] exp_ghr();
        logic [659:0] v;
        for (int i = 0; i < 20; i++)
            v[i*33 +: 33] = {mg_pc[i], mg_t[i]};
        return v;
    endfunction

    function automatic logic [16415:0] exp_w();
        logic [16415:0] v;
        for (int r = 0; r < 228; r++)
            for (int j = 0; j < 9; j++)
                v[r*72 + j*8 +: 8] = 8'(mw[r][j]);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [659:0]   eg;
        logic [16415:0] ew;
        int             bad;
        eg = exp_ghr();
        ew = exp_w();
        chk("pending", 64'(bus.o_pendingB_8), 64'(mq.size()));
        chk("push_ready", 64'(bus.o_pushReady), 64'((8 - mq.size() >= 4) && !m_train));
        chk("resolve_ready", 64'(bus.o_resolveReady), 64'(!m_train));
        chk("redirect", 64'(bus.o_redirect), 64'(e_redirect));
        chk("correct_pc", 64'(bus.o_correctPC_32), 64'(e_cpc));
        chk("proto_err", 64'(bus.o_protoErr), 64'(e_proto));
        checks++;
        assert (bus.o_globalHistoryRegister_660 === eg) else begin
            errors++;
            $error("FAIL ghr observed=%h expected=%h", bus.o_globalHistoryRegister_660, eg);
        end
        checks++;
        assert (bus.o_weightTable_16416 === ew) else begin
            errors++;
            bad = 0;
            for (int r = 227; r >= 0; r--)
                if (bus.o_weightTable_16416[r*72 +: 72] !== ew[r*72 +: 72]) bad = r;
            $error("FAIL weights row %0d observed=%h expected=%h", bad,
                   bus.o_weightTable_16416[bad*72 +: 72], ew[bad*72 +: 72]);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_in();
        bus.i_pushValid        = 1'b0;
        bus.i_pushNum_3        = 3'd0;
        bus.i_pushEntries_260  = '0;
        bus.i_resolveValid     = 1'b0;
        bus.i_resolveTaken     = 1'b0;
        bus.i_resolveTarget_32 = 32'd0;
    endtask

    task automatic set_slot(input int k, input logic [31:0] pc, input logic [31:0] tgt, input logic pt);
        bus.i_pushEntries_260[k*65 +: 65] = {tgt, pc, pt};
    endtask

    task automatic push1(input logic [31:0] pc, input logic [31:0] tgt, input logic pt);
        clear_in();
        bus.i_pushValid = 1'b1;
        bus.i_pushNum_3 = 3'd1;
        set_slot(0, pc, tgt, pt);
        step();
        clear_in();
    endtask

    task automatic resolve(input logic taken, input logic [31:0] target);
        clear_in();
        bus.i_resolveValid     = 1'b1;
        bus.i_resolveTaken     = taken;
        bus.i_resolveTarget_32 = target;
        step();
        clear_in();
    endtask

    task automatic mispredict_row0();
        push1(32'h1C8, 32'd0, 1'b0);
        resolve(1'b1, 32'h400);
        step();
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_pending", 64'(bus.o_pendingB_8), 64'd0);
        chk("rst_ghr_zero", 64'(bus.o_globalHistoryRegister_660 == '0), 64'd1);
        chk("rst_w_zero", 64'(bus.o_weightTable_16416 == '0), 64'd1);

        bus.i_pushValid = 1'b1;
        bus.i_pushNum_3 = 3'd3;
        set_slot(0, 32'h100, 32'd0, 1'b0);
        set_slot(1, 32'h200, 32'd0, 1'b0);
        set_slot(2, 32'h300, 32'd0, 1'b0);
        step();
        clear_in();
        chk("tp_pending3", 64'(bus.o_pendingB_8), 64'd3);
        chk("tp_push_ready", 64'(bus.o_pushReady), 64'd1);

        for (int i = 0; i < 3; i++) begin
            resolve(1'b0, 32'd0);
            chk("tp_no_redirect", 64'(bus.o_redirect), 64'd0);
        end
        chk("tp_ghr0", 64'(bus.o_globalHistoryRegister_660[32:0]), 64'({32'h300, 1'b0}));
        chk("tp_ghr2", 64'(bus.o_globalHistoryRegister_660[66 +: 33]), 64'({32'h100, 1'b0}));

        for (int i = 0; i < 8; i++) begin
            push1(32'h1000 + 32'(i * 4), 32'h2000, 1'b1);
            resolve(1'b1, 32'h2000);
        end
        push1(32'h1C8, 32'd0, 1'b0);
        resolve(1'b1, 32'h400);
        chk("tp_mis_redirect", 64'(bus.o_redirect), 64'd1);
        chk("tp_mis_cpc", 64'(bus.o_correctPC_32), 64'h400);
        chk("tp_train_pready", 64'(bus.o_pushReady), 64'd0);
        chk("tp_train_rready", 64'(bus.o_resolveReady), 64'd0);
        step();
        chk("tp_row0_plus1", 64'(bus.o_weightTable_16416[71:0] == {9{8'h01}}), 64'd1);
        chk("tp_redirect_drop", 64'(bus.o_redirect), 64'd0);
        chk("tp_ready_back", 64'(bus.o_resolveReady), 64'd1);

        for (int i = 0; i < 126; i++)
            mispredict_row0();
        chk("tp_row0_sat", 64'(bus.o_weightTable_16416[71:0] == {9{8'h7F}}), 64'd1);
        for (int i = 0; i < 3; i++)
            mispredict_row0();
        chk("tp_row0_hold", 64'(bus.o_weightTable_16416[71:0] == {9{8'h7F}}), 64'd1);
        push1(32'h1C8, 32'h400, 1'b1);
        resolve(1'b0, 32'd0);
        step();
        chk("tp_row0_dec", 64'(bus.o_weightTable_16416[71:0] == {9{8'h7E}}), 64'd1);

        push1(32'h40, 32'h600, 1'b1);
        resolve(1'b1, 32'h500);
        chk("tp_tgt_redirect", 64'(bus.o_redirect), 64'd1);
        chk("tp_tgt_cpc", 64'(bus.o_correctPC_32), 64'h500);
        chk("tp_tgt_ready", 64'(bus.o_resolveReady), 64'd1);
        step();

        resolve(1'b1, 32'd0);
        chk("tp_proto", 64'(bus.o_protoErr), 64'd1);
        step();
        chk("tp_proto_pulse", 64'(bus.o_protoErr), 64'd0);

        bus.i_pushValid = 1'b1;
        bus.i_pushNum_3 = 3'd4;
        for (int k = 0; k < 4; k++)
            set_slot(k, 32'h800 + 32'(k * 4), 32'd0, 1'b0);
        step();
        clear_in();
        push1(32'h900, 32'd0, 1'b0);
        chk("tp_full_ready", 64'(bus.o_pushReady), 64'd0);
        bus.i_pushValid = 1'b1;
        bus.i_pushNum_3 = 3'd4;
        step();
        clear_in();
        chk("tp_drop_pending", 64'(bus.o_pendingB_8), 64'd5);

        rst = 1'b1;
        step();
        rst = 1'b0;
        push1(32'h1C8, 32'd0, 1'b0);
        resolve(1'b1, 32'h400);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("tp_rst_in_train", 64'(bus.o_weightTable_16416 == '0), 64'd1);

        for (int c = 0; c < 1500; c++) begin
            clear_in();
            rst                = ($urandom_range(0, 299) == 0);
            bus.i_pushValid    = $urandom_range(0, 1);
            bus.i_pushNum_3    = 3'($urandom_range(0, 7));
            for (int k = 0; k < 4; k++)
                set_slot(k, 32'($urandom_range(0, 4095)) << 2, $urandom, 1'($urandom_range(0, 1)));
            bus.i_resolveValid = ($urandom_range(0, 2) != 0);
            bus.i_resolveTaken = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                bus.i_resolveTarget_32 = mq[0].tgt;
            else
                bus.i_resolveTarget_32 = $urandom;
            step();
        end
        rst = 1'b0;
        clear_in();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
